// File: rtl/shift_reg_univ.sv
// Universal shift register with an autonomous serializer.
// Manual modes: hold, shift left, shift right, parallel load. A start request
// loads d and shifts it out on ser_out, one bit per enabled cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             clock enable (done still clears while en is low)
//   mode[1:0]      00 hold, 01 shift left, 10 shift right, 11 load d
//   d[WIDTH-1:0]   parallel data for load and serialization
//   sl_in, sr_in   serial fill bits for left / right shifts
//   start          request a serialization of d (sampled while idle)
//   q              register contents
//   ser_out        q[WIDTH-1] if MSB_FIRST, else q[0]
//   busy, done     frame active / one-cycle end-of-frame pulse
module shift_reg_univ #(
  parameter int unsigned      WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shl_c, shr_c;

  // Shifted candidates; shift operators keep WIDTH=1 legal (no empty slices).
  always_comb begin
    shl_c = (q_q << 1) | WIDTH'(sl_in);
    shr_c = (q_q >> 1) | (WIDTH'(sr_in) << (WIDTH - 1));
  end

  // Next-state: en gates everything except the done pulse, which always clears.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (en) begin
      if (busy_q) begin
        if (cnt_q != '0) begin
          q_d   = MSB_FIRST ? shl_c : shr_c;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else if (start) begin
        q_d    = d;
        busy_d = 1'b1;
        cnt_d  = CNT_W'(WIDTH - 1);
      end else begin
        unique case (mode)
          MODE_HOLD:  q_d = q_q;
          MODE_LEFT:  q_d = shl_c;
          MODE_RIGHT: q_d = shr_c;
          MODE_LOAD:  q_d = d;
          default:    q_d = q_q;
        endcase
      end
    end
  end

  // State registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: an 8-bit MSB-first instance (a_),
// an 8-bit LSB-first instance (b_) and a 1-bit instance (c_).
module tb_shift_reg_univ;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: WIDTH=8, MSB_FIRST=1, RST_VAL=A5
  logic       a_rst, a_en, a_sl_in, a_sr_in, a_start;
  logic [1:0] a_mode;
  logic [7:0] a_d, a_q;
  logic       a_ser_out, a_busy, a_done;
  // Instance b: WIDTH=8, MSB_FIRST=0, RST_VAL=A5
  logic       b_rst, b_en, b_sl_in, b_sr_in, b_start;
  logic [1:0] b_mode;
  logic [7:0] b_d, b_q;
  logic       b_ser_out, b_busy, b_done;
  // Instance c: WIDTH=1, defaults otherwise
  logic       c_rst, c_en, c_sl_in, c_sr_in, c_start;
  logic [1:0] c_mode;
  logic [0:0] c_d, c_q;
  logic       c_ser_out, c_busy, c_done;

  shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b1), .RST_VAL(8'hA5)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .d(a_d),
    .sl_in(a_sl_in), .sr_in(a_sr_in), .start(a_start),
    .q(a_q), .ser_out(a_ser_out), .busy(a_busy), .done(a_done));

  shift_reg_univ #(.WIDTH(8), .MSB_FIRST(1'b0), .RST_VAL(8'hA5)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .d(b_d),
    .sl_in(b_sl_in), .sr_in(b_sr_in), .start(b_start),
    .q(b_q), .ser_out(b_ser_out), .busy(b_busy), .done(b_done));

  shift_reg_univ #(.WIDTH(1)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .d(c_d),
    .sl_in(c_sl_in), .sr_in(c_sr_in), .start(c_start),
    .q(c_q), .ser_out(c_ser_out), .busy(c_busy), .done(c_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] msb_bits;
    logic [7:0] lsb_bits;
    bit         saw_done;

    a_rst = 1; a_en = 0; a_mode = 2'b00; a_d = '0; a_sl_in = 0; a_sr_in = 0; a_start = 0;
    b_rst = 1; b_en = 0; b_mode = 2'b00; b_d = '0; b_sl_in = 0; b_sr_in = 0; b_start = 0;
    c_rst = 1; c_en = 0; c_mode = 2'b00; c_d = '0; c_sl_in = 0; c_sr_in = 0; c_start = 0;

    // Reset for two edges
    tick(); tick();
    check("rst_q",    64'(a_q), 64'h A5);
    check("rst_busy", 64'(a_busy), 64'h0);
    check("rst_done", 64'(a_done), 64'h0);
    check("rst_q_b",  64'(b_q), 64'hA5);
    check("rst_q_c",  64'(c_q), 64'h0);

    // Parallel load
    a_rst = 0; b_rst = 0; c_rst = 0;
    a_en = 1; a_mode = 2'b11; a_d = 8'h3C;
    tick();
    check("load_3c", 64'(a_q), 64'h3C);

    // Manual shifts and enable hold
    a_d = 8'h81;
    tick();
    check("load_81", 64'(a_q), 64'h81);
    a_mode = 2'b01; a_sl_in = 1;
    tick();
    check("shl_03", 64'(a_q), 64'h03);
    a_mode = 2'b10; a_sr_in = 0;
    tick();
    check("shr_01", 64'(a_q), 64'h01);
    a_en = 0; a_mode = 2'b01;
    tick(); tick(); tick();
    check("en_hold", 64'(a_q), 64'h01);

    // MSB-first frame of B4; mode=11 and a start pulse mid-frame are ignored
    msb_bits = 8'b1011_0100;
    a_en = 1; a_mode = 2'b00; a_d = 8'hB4; a_start = 1;
    tick();
    a_start = 0; a_mode = 2'b11; a_d = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("msb_bit%0d", k), 64'(a_ser_out), 64'(msb_bits[7-k]));
      check($sformatf("msb_busy%0d", k), 64'(a_busy), 64'h1);
      check($sformatf("msb_done%0d", k), 64'(a_done), 64'h0);
      a_start = (k == 3);
      tick();
    end
    a_start = 0;
    check("msb_end_busy", 64'(a_busy), 64'h0);
    check("msb_end_done", 64'(a_done), 64'h1);
    check("msb_end_q",    64'(a_q), 64'h7F);
    a_mode = 2'b00;
    tick();
    check("msb_done_clr", 64'(a_done), 64'h0);
    check("msb_idle_q",   64'(a_q), 64'h7F);

    // LSB-first frame with en alternating 0,1: 16 cycles, same bit order
    lsb_bits = 8'hB4;
    b_en = 1; b_d = 8'hB4; b_start = 1; b_sr_in = 0;
    tick();
    b_start = 0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("lsb_bit_c%0d", c), 64'(b_ser_out), 64'(lsb_bits[c/2]));
      check($sformatf("lsb_busy_c%0d", c), 64'(b_busy), 64'h1);
      b_en = (c % 2 == 1);
      tick();
    end
    check("lsb_end_busy", 64'(b_busy), 64'h0);
    check("lsb_end_done", 64'(b_done), 64'h1);
    check("lsb_end_q",    64'(b_q), 64'h01);
    b_en = 0;
    tick();
    check("lsb_done_clr_en0", 64'(b_done), 64'h0);

    // Reset after the third bit of an MSB-first frame
    a_en = 1; a_d = 8'hB4; a_start = 1;
    tick();
    a_start = 0;
    tick(); tick();
    check("abort_bit2", 64'(a_ser_out), 64'h1);
    a_rst = 1;
    tick();
    a_rst = 0;
    check("abort_busy", 64'(a_busy), 64'h0);
    check("abort_q",    64'(a_q), 64'hA5);
    check("abort_done", 64'(a_done), 64'h0);
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_done) saw_done = 1;
    end
    check("abort_no_done", 64'(saw_done), 64'h0);

    // WIDTH=1: manual shifts
    c_en = 1; c_mode = 2'b01; c_sl_in = 1;
    tick();
    check("w1_shl", 64'(c_q), 64'h1);
    c_mode = 2'b10; c_sr_in = 0;
    tick();
    check("w1_shr", 64'(c_q), 64'h0);

    // WIDTH=1: single frame
    c_mode = 2'b00; c_d = 1'b1; c_start = 1;
    tick();
    c_start = 0;
    check("w1_ser",  64'(c_ser_out), 64'h1);
    check("w1_busy", 64'(c_busy), 64'h1);
    check("w1_done0", 64'(c_done), 64'h0);
    tick();
    check("w1_done1", 64'(c_done), 64'h1);
    check("w1_idle",  64'(c_busy), 64'h0);
    tick();
    check("w1_done_clr", 64'(c_done), 64'h0);

    // WIDTH=1: start held high gives back-to-back frames
    c_start = 1; c_d = 1'b1;
    tick();
    check("w1_bb_busy_a", 64'(c_busy), 64'h1);
    check("w1_bb_q_a",    64'(c_q), 64'h1);
    tick();
    check("w1_bb_done_a", 64'(c_done), 64'h1);
    check("w1_bb_idle_a", 64'(c_busy), 64'h0);
    c_d = 1'b0;
    tick();
    check("w1_bb_busy_b", 64'(c_busy), 64'h1);
    check("w1_bb_q_b",    64'(c_q), 64'h0);
    check("w1_bb_done_b", 64'(c_done), 64'h0);
    tick();
    check("w1_bb_done_b2", 64'(c_done), 64'h1);
    c_start = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
